ssd_scan_ctrl: RTL and testbench
================================

Name: ssd_scan_ctrl

Overview:
- Time-multiplexed seven-segment display scan controller, sequenced by a divided clock level from the clock divider (e.g. the ~150 Hz output).
- Walks the digit select across DIGITS positions and presents each digit's BCD code.
- Inserts a blanking interval between digits to suppress ghosting.
- Applies 8-level brightness by frame-based PWM.
- Sits between the divider and the SSD decoder/pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- BLANK_CYC, 16, clk cycles of all-off blanking after each digit advance (1..255). Must be shorter than one scan_clk period.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- scan_clk  in  1  divided clock level from the divider; asynchronous to this logic's sampling, treated as data.
- en  in  1  scan enable; 0 forces all digits off.
- din  in  4*DIGITS  BCD codes; digit k = din[4k+3:4k].
- digit_mask  in  DIGITS  1 = digit k may light.
- bright  in  3  brightness; digits lit in (bright+1) of every 8 frames.
- ssd_ctl  out  DIGITS  digit select, active-low, registered.
- bcd_out  out  4  BCD code of the selected digit, registered.
- frame_done  out  1  one-clk pulse when the scan wraps from digit DIGITS-1 to digit 0.

Behaviour:
- Reset (async, rst=1):
  - ssd_ctl = all 1s; bcd_out = 0; frame_done = 0.
  - idx = 0; frame = 0; state = IDLE; sync/edge flops = 0.
- Tick generation:
  - scan_clk passes through a 2-flop synchronizer, then a registered rising-edge detect.
  - The tick is a one-clk pulse, 3 clk edges after scan_clk is first sampled high.
  - Exactly one tick per scan_clk rising edge; none on falling edges.
- IDLE:
  - ssd_ctl all 1s; bcd_out = 0; idx and frame held at 0.
  - en=1 -> BLANK and load blank_cnt = BLANK_CYC.
- BLANK:
  - ssd_ctl all 1s; bcd_out = code of digit idx.
  - blank_cnt decrements each clk; at 1 -> DRIVE. BLANK therefore lasts exactly BLANK_CYC clks.
  - A tick arriving in BLANK is dropped; idx does not advance and the slot stretches.
- DRIVE:
  - bcd_out = din[4*idx+:4], re-sampled every clk so live data changes propagate with 1 clk latency.
  - ssd_ctl[idx] = 0 iff digit_mask[idx]=1 and frame <= bright. All other bits are 1.
  - On tick:
    - idx advances, wrapping DIGITS-1 -> 0.
    - On wrap, frame increments (7 -> 0) and frame_done pulses in the same clk as the state change.
    - Next state is BLANK with blank_cnt reloaded.
- en=0 in any state:
  - Next clk goes to IDLE; ssd_ctl all 1s on that edge.
  - idx and frame clear; any pending tick is discarded.
- Output invariants:
  - At most one ssd_ctl bit is 0 at any time.
  - Never more than one digit lit during BLANK->DRIVE or DRIVE->BLANK transitions; ssd_ctl is registered from state/idx, so there is no glitch.
- Simultaneous events: en falling in the same clk as a tick -> IDLE wins; no advance, no frame_done.
- Widths:
  - idx width = ceil(log2(DIGITS)), minimum 1.
  - frame is 3 bits; the compare frame <= bright is unsigned 3-bit.
  - blank_cnt is 8 bits.
- Mid-operation reset: outputs return to reset values asynchronously; scan restarts from digit 0, frame 0.

Test Plan:
- Basic scan (DIGITS=4, BLANK_CYC=4, scan_clk period 64 clk, en=1, mask=4'b1111, bright=7, din=16'h4321):
  - Expected ssd_ctl sequence: 1110/bcd 1 -> 1101/bcd 2 -> 1011/bcd 3 -> 0111/bcd 4 -> 1110.
  - Each select is preceded by exactly 4 clks of 1111.
  - frame_done pulses once per 4 ticks.
- Tick latency:
  - scan_clk rises -> idx changes on the 3rd clk edge after first sampling.
  - scan_clk held high 200 clks -> exactly one advance.
- Brightness (bright=1):
  - Over 8 consecutive frames, digits light only in frames 0 and 1.
  - Frames 2..7 keep ssd_ctl=1111 while bcd_out still cycles.
- Mask (digit_mask=4'b1010): digits 0 and 2 never drive a 0; slots still consume time; digits 1 and 3 light normally.
- Enable/blank corner cases:
  - en dropped in DRIVE on digit 2 -> ssd_ctl=1111 next clk.
  - en reasserted -> first lit digit is 0 after 4 blank clks.
  - Tick injected during BLANK (BLANK_CYC=40, scan_clk period 32) -> dropped; idx advances only on ticks seen in DRIVE.
- Async reset: rst pulsed mid-DRIVE, between clk edges -> ssd_ctl=1111, bcd_out=0 immediately, without waiting for a clk edge; scan resumes from digit 0.

Source files
------------

// File: rtl/ssd_scan_ctrl.sv
// Seven-segment scan controller: advances the digit select on each scan_clk rise,
// blanks between digits and dims the display by frame-based PWM.
module ssd_scan_ctrl #(
    parameter int DIGITS    = 4,
    parameter int BLANK_CYC = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_clk,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     digit_mask,
    input  logic [2:0]            bright,
    output logic [DIGITS-1:0]     ssd_ctl,
    output logic [3:0]            bcd_out,
    output logic                  frame_done
);
    localparam int               IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);
    localparam logic [7:0]       BLANK_LOAD = 8'(BLANK_CYC);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    logic              sync1_q, sync2_q, sync3_q, tick_q;
    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [2:0]        frame_q, frame_d;
    logic [7:0]        blank_cnt_q, blank_cnt_d;
    logic [DIGITS-1:0] ssd_ctl_q, ssd_ctl_d;
    logic [3:0]        bcd_q, bcd_d;
    logic              frame_done_q, frame_done_d;
    logic [3:0]        code_sel;
    logic              mask_sel;

    // scan_clk is asynchronous: two-flop synchronizer, then a registered rising-edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            sync1_q <= scan_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            tick_q  <= sync2_q & ~sync3_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_d      = frame_q;
        blank_cnt_d  = blank_cnt_q;
        frame_done_d = 1'b0;
        if (!en) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            frame_d     = 3'd0;
            blank_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_BLANK;
                    blank_cnt_d = BLANK_LOAD;
                end
                ST_BLANK: begin
                    // ticks landing here are dropped on purpose: the slot simply stretches
                    if (blank_cnt_q <= 8'd1) begin
                        state_d = ST_DRIVE;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 8'd1;
                    end
                end
                ST_DRIVE: begin
                    if (tick_q) begin
                        state_d     = ST_BLANK;
                        blank_cnt_d = BLANK_LOAD;
                        if (idx_q == IDX_LAST) begin
                            idx_d        = '0;
                            frame_d      = frame_q + 3'd1;
                            frame_done_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register glitch-free with it
    always_comb begin
        code_sel = 4'd0;
        mask_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                code_sel = din[4*k +: 4];
                mask_sel = digit_mask[k];
            end
        end
    end

    always_comb begin
        ssd_ctl_d = '1;
        bcd_d     = (state_d == ST_IDLE) ? 4'd0 : code_sel;
        if (state_d == ST_DRIVE && mask_sel && frame_d <= bright) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (idx_d == IDX_W'(k)) begin
                    ssd_ctl_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            frame_q      <= 3'd0;
            blank_cnt_q  <= 8'd0;
            ssd_ctl_q    <= '1;
            bcd_q        <= 4'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_q      <= frame_d;
            blank_cnt_q  <= blank_cnt_d;
            ssd_ctl_q    <= ssd_ctl_d;
            bcd_q        <= bcd_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ssd_ctl    = ssd_ctl_q;
    assign bcd_out    = bcd_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a slot/frame reference model predicts every
// clock's outputs; a separate monitor pops and compares them after each edge.
module tb_ssd_scan_ctrl;
    localparam int DIGITS    = 4;
    localparam int BLANK_CYC = 4;
    localparam int DW        = 4 * DIGITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              scan_clk = 1'b0;
    logic              en = 1'b0;
    logic [DW-1:0]     din = '0;
    logic [DIGITS-1:0] digit_mask = '1;
    logic [2:0]        bright = 3'd7;
    logic [DIGITS-1:0] ssd_ctl;
    logic [3:0]        bcd_out;
    logic              frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [DIGITS-1:0] ssd;
        logic [3:0]        bcd;
        logic              fd;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    int m_cyc = 0;
    bit m_prev_s = 1'b0;
    int tick_at[$];
    bit m_run = 1'b0;
    int m_idx = 0;
    int m_frame = 0;
    int m_blank = 0;

    int hp_left = 1;
    int en_hold = 0;

    ssd_scan_ctrl #(.DIGITS(DIGITS), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .scan_clk   (scan_clk),
        .en         (en),
        .din        (din),
        .digit_mask (digit_mask),
        .bright     (bright),
        .ssd_ctl    (ssd_ctl),
        .bcd_out    (bcd_out),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic exp_t reset_exp();
        exp_t e;
        e.ssd = '1;
        e.bcd = 4'd0;
        e.fd  = 1'b0;
        return e;
    endfunction

    function automatic void model_reset();
        m_prev_s = 1'b0;
        tick_at.delete();
        m_run   = 1'b0;
        m_idx   = 0;
        m_frame = 0;
        m_blank = 0;
    endfunction

    // One clock edge: a scan_clk rise seen at edge k becomes an advance request at edge k+3.
    function automatic exp_t model_edge();
        exp_t e;
        bit tick;
        bit wrap;
        m_cyc++;
        tick = 1'b0;
        while (tick_at.size() > 0 && tick_at[0] <= m_cyc) begin
            if (tick_at[0] == m_cyc) tick = 1'b1;
            void'(tick_at.pop_front());
        end
        if (scan_clk && !m_prev_s) tick_at.push_back(m_cyc + 3);
        m_prev_s = scan_clk;
        wrap = 1'b0;
        if (!en) begin
            m_run = 1'b0; m_idx = 0; m_frame = 0; m_blank = 0;
        end else if (!m_run) begin
            m_run = 1'b1; m_blank = BLANK_CYC;
        end else if (m_blank > 0) begin
            m_blank--;
        end else if (tick) begin
            wrap  = (m_idx == DIGITS - 1);
            m_idx = (m_idx + 1) % DIGITS;
            if (wrap) m_frame = (m_frame + 1) % 8;
            m_blank = BLANK_CYC;
        end
        e.ssd = '1;
        e.bcd = 4'd0;
        e.fd  = wrap;
        if (m_run) e.bcd = din[4*m_idx +: 4];
        if (m_run && m_blank == 0 && digit_mask[m_idx] && m_frame <= int'(bright)) e.ssd[m_idx] = 1'b0;
        return e;
    endfunction

    task automatic check_reset(input string name);
        n_tests++;
        if (ssd_ctl !== '1 || bcd_out !== 4'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got ssd=%b bcd=%h fd=%b, expected ssd=%b bcd=0 fd=0",
                     name, ssd_ctl, bcd_out, frame_done, {DIGITS{1'b1}});
        end
    endtask

    // Called at a negedge; returns at a negedge with one expectation pushed per posedge passed.
    task automatic run_phase(input int ncyc, input int hp_min, input int hp_max,
                             input int p_en_drop, input int p_din, input bit rnd_cfg,
                             input int n_drop2, input int p_rst);
        int drops = n_drop2;
        en = 1'b1;
        en_hold = 0;
        hp_left = 1;
        for (int c = 0; c < ncyc; c++) begin
            if (p_rst > 0 && $urandom_range(999, 0) < p_rst) begin
                #2 rst = 1'b1;
                #1 check_reset("async_rst");
                model_reset();
                exp_q.push_back(reset_exp());
                @(negedge clk);
                rst = 1'b0;
            end
            if (hp_left <= 1) begin
                scan_clk = ~scan_clk;
                hp_left = int'($urandom_range(hp_max, hp_min));
            end else begin
                hp_left--;
            end
            if (en_hold > 0) begin
                en_hold--;
                if (en_hold == 0) en = 1'b1;
            end else if (drops > 0 && m_run && m_blank == 0 && m_idx == 2) begin
                en = 1'b0;
                en_hold = 3;
                drops--;
            end else if (p_en_drop > 0 && $urandom_range(999, 0) < p_en_drop) begin
                en = 1'b0;
                en_hold = int'($urandom_range(6, 1));
            end
            if (p_din > 0 && $urandom_range(99, 0) < p_din) din = DW'($urandom);
            if (rnd_cfg && $urandom_range(99, 0) == 0) begin
                digit_mask = DIGITS'($urandom);
                bright = 3'($urandom_range(7, 0));
            end
            exp_q.push_back(model_edge());
            @(negedge clk);
        end
    endtask

    // monitor: compare every registered output update against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (ssd_ctl !== e.ssd || bcd_out !== e.bcd || frame_done !== e.fd) begin
                    n_fail++;
                    $display("FAIL scan t=%0t: got ssd=%b bcd=%h fd=%b, expected ssd=%b bcd=%h fd=%b",
                             $time, ssd_ctl, bcd_out, frame_done, e.ssd, e.bcd, e.fd);
                end
                n_tests++;
                if ($countones(~ssd_ctl) > 1) begin
                    n_fail++;
                    $display("FAIL one_digit t=%0t: got ssd=%b, expected at most one low bit",
                             $time, ssd_ctl);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion before t=1000000");
        $fatal(1, "watchdog");
    end

    initial begin
        din = 16'h4321;
        repeat (2) @(negedge clk);
        check_reset("reset_state");
        rst = 1'b0;
        model_reset();
        // basic scan, full brightness
        run_phase(700, 32, 32, 0, 0, 1'b0, 0, 0);
        // scan_clk held high for long stretches
        run_phase(1000, 200, 200, 0, 0, 1'b0, 0, 0);
        // PWM: lit only in frames 0 and 1
        bright = 3'd1;
        run_phase(1200, 8, 8, 0, 0, 1'b0, 0, 0);
        // masked digits still consume their slots
        bright = 3'd7;
        digit_mask = 4'b1010;
        run_phase(400, 10, 12, 0, 5, 1'b0, 0, 0);
        // enable dropped while driving digit 2, then restart
        digit_mask = 4'b1111;
        run_phase(400, 12, 12, 0, 0, 1'b0, 3, 0);
        // scan period near the blank length: many ticks land in BLANK
        run_phase(400, 2, 3, 0, 0, 1'b0, 0, 0);
        // everything randomized, including mid-run async resets
        run_phase(4000, 1, 24, 5, 10, 1'b1, 0, 2);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
